// File: rtl/nes_input_pkg.sv
// Shared definitions for the NES joypad port: button order, USB HID keycodes and register addresses.
package nes_input_pkg;

  localparam int unsigned NumButtons = 8;

  // Bit positions in the standard-controller shift order (A is shifted out first).
  typedef enum logic [2:0] {
    BtnA,
    BtnB,
    BtnSelect,
    BtnStart,
    BtnUp,
    BtnDown,
    BtnLeft,
    BtnRight
  } button_e;

  localparam logic [7:0] KEY_J     = 8'h0D;
  localparam logic [7:0] KEY_K     = 8'h0E;
  localparam logic [7:0] KEY_SPACE = 8'h2C;
  localparam logic [7:0] KEY_ENTER = 8'h28;
  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_D     = 8'h07;

  localparam logic [15:0] ADDR_JOY1 = 16'h4016;
  localparam logic [15:0] ADDR_JOY2 = 16'h4017;

  // None of the mapped keycodes is 8'h00, so "no key" never matches a button.
  function automatic logic [7:0] key_for_button(input int unsigned idx);
    logic [7:0] key;
    case (idx)
      int'(BtnA):      key = KEY_J;
      int'(BtnB):      key = KEY_K;
      int'(BtnSelect): key = KEY_SPACE;
      int'(BtnStart):  key = KEY_ENTER;
      int'(BtnUp):     key = KEY_W;
      int'(BtnDown):   key = KEY_S;
      int'(BtnLeft):   key = KEY_A;
      int'(BtnRight):  key = KEY_D;
      default:         key = 8'h00;
    endcase
    return key;
  endfunction

endpackage

// File: rtl/button_hold_timer.sv
// Per-button hold timer: keeps a button pressed for KEY_HOLD_CYCLES clocks after its keycode was
// last seen, bridging gaps between USB reports.
module button_hold_timer #(
  parameter int unsigned KEY_HOLD_CYCLES = 1_000_000
) (
  input  logic Clk,
  input  logic Reset,
  input  logic match,
  output logic pressed
);

  localparam int unsigned CntW = $clog2(KEY_HOLD_CYCLES + 1);
  localparam logic [CntW-1:0] HoldLoad = CntW'(KEY_HOLD_CYCLES);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (match) begin
      cnt_d = HoldLoad;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign pressed = (cnt_q != '0);

endmodule

// File: rtl/nes_controller_port.sv
// CPU-side responder for $4016/$4017: turns the SoC keycode into controller-1 state and serves
// the 6502 strobe / serial-read protocol with it.
module nes_controller_port
  import nes_input_pkg::*;
#(
  parameter int unsigned KEY_HOLD_CYCLES = 1_000_000,
  parameter logic [7:0]  OPEN_BUS_BITS   = 8'h40
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [7:0]  keycode,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_rw_n,
  input  logic        cpu_access,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_rdata_sel,
  output logic [7:0]  buttons_debug
);

  logic [NumButtons-1:0] pressed;

  for (genvar i = 0; i < NumButtons; i++) begin : g_btn
    localparam logic [7:0] Key = key_for_button(i);
    logic match;
    assign match = (keycode == Key);

    button_hold_timer #(
      .KEY_HOLD_CYCLES(KEY_HOLD_CYCLES)
    ) u_timer (
      .Clk    (Clk),
      .Reset  (Reset),
      .match  (match),
      .pressed(pressed[i])
    );
  end

  assign buttons_debug = pressed;

  logic       strobe_q, strobe_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rdata_q, rdata_d;
  logic       sel_q, sel_d;

  logic unused_wdata;
  assign unused_wdata = ^cpu_wdata[7:1];

  always_comb begin
    strobe_d = strobe_q;
    shift_d  = shift_q;
    rdata_d  = rdata_q;
    sel_d    = sel_q;

    // Strobe high keeps the shifter tracking the live buttons, so reads return A.
    if (strobe_q) begin
      shift_d = pressed;
    end

    if (cpu_access) begin
      if (!cpu_rw_n) begin
        sel_d = 1'b0;
        if (cpu_addr == ADDR_JOY1) begin
          strobe_d = cpu_wdata[0];
        end
      end else if (cpu_addr == ADDR_JOY1) begin
        rdata_d = {OPEN_BUS_BITS[7:1], shift_q[0]};
        sel_d   = 1'b1;
        // Shift in ones so reads past the eighth return 1, as on real hardware.
        if (!strobe_q) begin
          shift_d = {1'b1, shift_q[7:1]};
        end
      end else if (cpu_addr == ADDR_JOY2) begin
        rdata_d = {OPEN_BUS_BITS[7:1], 1'b0};
        sel_d   = 1'b1;
      end else begin
        sel_d = 1'b0;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      strobe_q <= 1'b0;
      shift_q  <= 8'h00;
      rdata_q  <= 8'h00;
      sel_q    <= 1'b0;
    end else begin
      strobe_q <= strobe_d;
      shift_q  <= shift_d;
      rdata_q  <= rdata_d;
      sel_q    <= sel_d;
    end
  end

  assign cpu_rdata     = rdata_q;
  assign cpu_rdata_sel = sel_q;

endmodule

// File: tb/tb_nes_controller_port.sv
// Directed self-checking bench for nes_controller_port with a 4-cycle key hold.
module tb_nes_controller_port;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [7:0]  keycode = 8'h00;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_wdata = 8'h00;
  logic        cpu_rw_n = 1'b1;
  logic        cpu_access = 1'b0;
  logic [7:0]  cpu_rdata;
  logic        cpu_rdata_sel;
  logic [7:0]  buttons_debug;

  int n_cmp = 0;
  int n_bad = 0;

  nes_controller_port #(
    .KEY_HOLD_CYCLES(4),
    .OPEN_BUS_BITS  (8'h40)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .keycode      (keycode),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_rw_n     (cpu_rw_n),
    .cpu_access   (cpu_access),
    .cpu_rdata    (cpu_rdata),
    .cpu_rdata_sel(cpu_rdata_sel),
    .buttons_debug(buttons_debug)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h, expected %02h", tag, got, exp);
    end
  endtask

  // One bus cycle; returns at the following falling edge, after the response register updated.
  task automatic bus(input logic [15:0] a, input logic [7:0] d, input logic rw);
    @(negedge Clk);
    cpu_addr   = a;
    cpu_wdata  = d;
    cpu_rw_n   = rw;
    cpu_access = 1'b1;
    @(negedge Clk);
    cpu_access = 1'b0;
  endtask

  task automatic rd_joy1(input string tag, input logic [7:0] exp);
    bus(16'h4016, 8'h00, 1'b1);
    check(tag, cpu_rdata, exp);
  endtask

  task automatic strobe_pulse();
    bus(16'h4016, 8'h01, 1'b0);
    bus(16'h4016, 8'h00, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge Clk);
  endtask

  initial begin
    // Reset state
    idle(2);
    Reset = 1'b0;
    check("rst_rdata", cpu_rdata, 8'h00);
    check("rst_sel", {7'd0, cpu_rdata_sel}, 8'h01 & 8'h00);
    check("rst_buttons", buttons_debug, 8'h00);
    rd_joy1("rst_rd", 8'h40);
    check("rst_rd_sel", {7'd0, cpu_rdata_sel}, 8'h01);

    // A held: full serial sequence plus trailing ones
    keycode = 8'h0D;
    idle(2);
    check("a_buttons", buttons_debug, 8'h01);
    strobe_pulse();
    for (int i = 0; i < 10; i++) begin
      rd_joy1($sformatf("a_rd%0d", i), (i == 0 || i >= 8) ? 8'h41 : 8'h40);
    end

    // Right held: strobe-high reads keep returning A, then Right on the eighth read
    keycode = 8'h07;
    idle(6);
    check("r_buttons", buttons_debug, 8'h80);
    bus(16'h4016, 8'h01, 1'b0);
    for (int i = 0; i < 3; i++) rd_joy1($sformatf("r_strb_rd%0d", i), 8'h40);
    bus(16'h4016, 8'h00, 1'b0);
    for (int i = 1; i <= 8; i++) rd_joy1($sformatf("r_rd%0d", i), (i == 8) ? 8'h41 : 8'h40);

    // Unrelated address: select drops, data holds
    bus(16'h2002, 8'h00, 1'b1);
    check("other_sel", {7'd0, cpu_rdata_sel}, 8'h00);
    check("other_hold", cpu_rdata, 8'h41);

    // One-cycle Up press is stretched to exactly 4 cycles
    keycode = 8'h00;
    idle(8);
    check("idle_buttons", buttons_debug, 8'h00);
    keycode = 8'h1A;
    @(negedge Clk);
    check("up_c1", buttons_debug, 8'h10);
    keycode = 8'h00;
    for (int i = 2; i <= 4; i++) begin
      @(negedge Clk);
      check($sformatf("up_c%0d", i), buttons_debug, 8'h10);
    end
    @(negedge Clk);
    check("up_off", buttons_debug, 8'h00);

    // $4017 read/write must not disturb controller 1
    keycode = 8'h0D;
    idle(2);
    strobe_pulse();
    bus(16'h4017, 8'h00, 1'b1);
    check("j2_rd", cpu_rdata, 8'h40);
    check("j2_sel", {7'd0, cpu_rdata_sel}, 8'h01);
    rd_joy1("j2_then_a", 8'h41);
    bus(16'h4017, 8'h01, 1'b0);
    check("j2_wr_sel", {7'd0, cpu_rdata_sel}, 8'h00);
    rd_joy1("j2_wr_then_b", 8'h40);

    // Reset mid-sequence
    strobe_pulse();
    rd_joy1("mid_rd0", 8'h41);
    rd_joy1("mid_rd1", 8'h40);
    rd_joy1("mid_rd2", 8'h40);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    check("mid_rst_rdata", cpu_rdata, 8'h00);
    check("mid_rst_sel", {7'd0, cpu_rdata_sel}, 8'h00);
    rd_joy1("mid_post_rst", 8'h40);
    strobe_pulse();
    for (int i = 0; i < 8; i++) rd_joy1($sformatf("mid_re%0d", i), (i == 0) ? 8'h41 : 8'h40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
